channel_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream flit channel between PORTS upstream traffic sources.
- All channels use the two-phase toggle req/ack protocol, with each flit formatted as {payload, destination}.
- Sits between a group of sources and a single router input port. It registers the granted flit, forwards it downstream, waits for the downstream ack, then acks the granted source.

---
 rtl/channel_arbiter.sv | 124 ++++++++++++
 tb/tb_channel_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/channel_arbiter.sv
// Round-robin arbiter that merges PORTS toggle req/ack flit channels into one downstream channel.
// Define ARB_FIXED_PRIORITY_EN to make the lowest pending index always win instead.
module channel_arbiter #(
  parameter  int PORTS      = 4,
  parameter  int SIZE       = 8,
  localparam int GRANT_BITS = $clog2(PORTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTS-1:0]        in_req,
  input  logic [PORTS*SIZE-1:0]   in_data,
  output logic [PORTS-1:0]        in_ack,
  output logic                    out_req,
  output logic [SIZE-1:0]         out_data,
  input  logic                    out_ack,
  output logic                    busy,
  output logic [GRANT_BITS-1:0]   grant
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PORTS-1:0]        ack_q, ack_d;
  logic                    req_q, req_d;
  logic [SIZE-1:0]         data_q, data_d;
  logic                    busy_q, busy_d;
  logic [GRANT_BITS-1:0]   grant_q, grant_d;

  logic [PORTS-1:0]        pending_s;
  logic                    any_s;
  logic                    done_s;
  logic                    found_s;
  logic [GRANT_BITS-1:0]   idx_s;
  logic [GRANT_BITS-1:0]   winner_s;

  // A channel is pending exactly while its request and ack toggles differ.
  assign pending_s = in_req ^ ack_q;
  assign any_s     = |pending_s;
  assign done_s    = busy_q && (out_ack == req_q);

  // Pick the first pending channel in search order; the last grant is checked last.
  always_comb begin
    found_s  = 1'b0;
    idx_s    = {GRANT_BITS{1'b0}};
    winner_s = grant_q;
    for (int k = 0; k < PORTS; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      idx_s = GRANT_BITS'(k);
`else
      idx_s = GRANT_BITS'((int'(grant_q) + 1 + k) % PORTS);
`endif
      if (!found_s && pending_s[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/WAIT handshake sequence.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    req_d   = req_q;
    data_d  = data_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          data_d  = in_data[winner_s*SIZE +: SIZE];
          req_d   = ~req_q;
          grant_d = winner_s;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          ack_d[grant_q] = ~ack_q[grant_q];
          busy_d         = 1'b0;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; grant resets to the last index so channel 0 goes first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ack_q   <= {PORTS{1'b0}};
      req_q   <= 1'b0;
      data_q  <= {SIZE{1'b0}};
      busy_q  <= 1'b0;
      grant_q <= GRANT_BITS'(PORTS - 1);
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
    end
  end

  assign in_ack   = ack_q;
  assign out_req  = req_q;
  assign out_data = data_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_channel_arbiter.sv
// Bench for channel_arbiter: directed protocol steps plus random traffic against a rule-level model.
module tb_channel_arbiter;
  localparam int PORTS = 4;
  localparam int SIZE  = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PORTS-1:0]      in_req;
  logic [PORTS*SIZE-1:0] in_data;
  logic [PORTS-1:0]      in_ack;
  logic                  out_req;
  logic [SIZE-1:0]       out_data;
  logic                  out_ack;
  logic                  busy;
  logic [1:0]            grant;

  int checks   = 0;
  int failures = 0;

  logic [PORTS-1:0] m_ack;
  logic             m_req;
  logic [SIZE-1:0]  m_data;
  logic             m_busy;
  int               m_grant;

  channel_arbiter #(.PORTS(PORTS), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ack   = '0;
    m_req   = 1'b0;
    m_data  = '0;
    m_busy  = 1'b0;
    m_grant = PORTS - 1;
  endtask

  // Winner = pending channel at the smallest round-robin distance after the last grant.
  task automatic model_step();
    logic [PORTS-1:0] pend;
    int win, bestd, d;
    if (reset !== 1'b1) begin
      model_reset();
    end else begin
      pend = in_req ^ m_ack;
      if (!m_busy) begin
        win   = -1;
        bestd = PORTS;
        for (int c = 0; c < PORTS; c++) begin
          if (pend[c]) begin
`ifdef ARB_FIXED_PRIORITY_EN
            d = c;
`else
            d = (c - m_grant - 1 + 2 * PORTS) % PORTS;
`endif
            if (d < bestd) begin
              bestd = d;
              win   = c;
            end
          end
        end
        if (win >= 0) begin
          m_data  = in_data[win*SIZE +: SIZE];
          m_req   = ~m_req;
          m_grant = win;
          m_busy  = 1'b1;
        end
      end else if (out_ack == m_req) begin
        m_ack[m_grant] = ~m_ack[m_grant];
        m_busy         = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ack", 32'(in_ack), 32'(m_ack));
    chk("out_req", 32'(out_req), 32'(m_req));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant", 32'(grant), 32'(m_grant));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    in_req  = '0;
    out_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  int exp_g;
  logic [PORTS-1:0] prev_ack;

  initial begin
    reset   = 1'b0;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;

    // Idle after reset: grant parked on the last channel
    repeat (5) tick();
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_in_ack", 32'(in_ack), 32'd0);

    // Single request on channel 2, downstream answers three cycles later
    in_data = 32'h00A5_0000;
    in_req  = 4'b0100;
    tick();
    chk("ch2_out_req", 32'(out_req), 32'd1);
    chk("ch2_out_data", 32'(out_data), 32'hA5);
    chk("ch2_grant", 32'(grant), 32'd2);
    chk("ch2_busy", 32'(busy), 32'd1);
    tick();
    tick();
    out_ack = 1'b1;
    tick();
    chk("ch2_in_ack", 32'(in_ack), 32'b0100);
    chk("ch2_idle", 32'(busy), 32'd0);

    // All four channels pending, each source re-toggles on its ack
    do_reset();
    in_data = 32'h4433_2211;
    in_req  = 4'b1111;
    for (int n = 0; n < 6; n++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_g = 0;
`else
      exp_g = n % PORTS;
`endif
      tick();
      chk("rr_grant", 32'(grant), 32'(exp_g));
      out_ack  = ~out_ack;
      prev_ack = in_ack;
      tick();
      chk("rr_ack_toggle", 32'(in_ack ^ prev_ack), 32'd1 << exp_g);
      in_req = in_req ^ (in_ack ^ prev_ack);
    end

    // Channels 1 and 3 pending with grant parked on 1
    do_reset();
    in_req = 4'b0010;
    tick();
    out_ack = ~out_ack;
    tick();
    chk("pre_grant1", 32'(grant), 32'd1);
    in_req = 4'b1000;
    tick();
`ifdef ARB_FIXED_PRIORITY_EN
    chk("pair_first", 32'(grant), 32'd1);
`else
    chk("pair_first", 32'(grant), 32'd3);
`endif
    out_ack = ~out_ack;
    tick();
    tick();
`ifdef ARB_FIXED_PRIORITY_EN
    chk("pair_second", 32'(grant), 32'd3);
`else
    chk("pair_second", 32'(grant), 32'd1);
`endif
    out_ack = ~out_ack;
    tick();

    // Asynchronous reset while a flit is outstanding
    do_reset();
    in_req = 4'b0001;
    tick();
    chk("pre_abort_req", 32'(out_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("abort_out_req", 32'(out_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    in_req  = '0;
    out_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    in_req = 4'b0001;
    tick();
    chk("post_abort_grant", 32'(grant), 32'd0);
    chk("post_abort_req", 32'(out_req), 32'd1);
    out_ack = 1'b1;
    tick();
    chk("post_abort_ack", 32'(in_ack), 32'b0001);

    // Stray downstream ack while idle is ignored
    out_ack = 1'b0;
    repeat (3) tick();
    chk("stray_req", 32'(out_req), 32'd1);
    chk("stray_in_ack", 32'(in_ack), 32'b0001);
    chk("stray_busy", 32'(busy), 32'd0);
    out_ack = 1'b1;

    // Random legal traffic with random downstream latency
    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < PORTS; c++) begin
        if ((in_req[c] == m_ack[c]) && ($urandom_range(0, 3) == 0)) begin
          in_req[c] = ~in_req[c];
        end
      end
      in_data = $urandom();
      if (m_busy && ($urandom_range(0, 2) == 0)) begin
        out_ack = m_req;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
